// File: rtl/stopwatch_core_if.sv
// rtl/stopwatch_core_if.sv - control/display signal bundle for stopwatch_core (lap input with STOPWATCH_LAP_HOLD_EN)
interface stopwatch_core_if;
    logic        clk1kHz;
    logic        start_stop;
    logic        clear;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap;
`endif
    logic [19:0] bcd_time;
    logic        running;
    logic        overflow;

`ifdef STOPWATCH_LAP_HOLD_EN
    modport master (output clk1kHz, start_stop, clear, lap,
                    input  bcd_time, running, overflow);
    modport slave  (input  clk1kHz, start_stop, clear, lap,
                    output bcd_time, running, overflow);
`else
    modport master (output clk1kHz, start_stop, clear,
                    input  bcd_time, running, overflow);
    modport slave  (input  clk1kHz, start_stop, clear,
                    output bcd_time, running, overflow);
`endif
endinterface

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD M:SS.hh stopwatch driven by a synchronised 1 kHz tick
// Optional display lap-hold enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_core #(
    parameter int unsigned TICK_DIV    = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk50MHz,
    input  logic              reset_n,
    stopwatch_core_if.slave   sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [3:0]  PRESC_MAX = 4'(TICK_DIV - 1);
    localparam logic [19:0] WRAP_TIME = 20'h95999;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick_q;

    state_e      state_q, state_d;
    logic [3:0]  presc_q, presc_d;
    logic [19:0] cnt_q, cnt_d;
    logic        running_q;
    logic        overflow_q, overflow_d;

    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (v[15:12] != 4'd5) begin
                        r[15:12] = v[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        r[19:16] = (v[19:16] != 4'd9) ? v[19:16] + 4'd1 : 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

    // clk1kHz is data here: synchronise, then register the rising-edge detect
    always_ff @(posedge clk50MHz) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw.clk1kHz};
            hist_q <= sync_q[SYNC_STAGES-1];
            tick_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sw.start_stop) state_d = RUN;
            RUN:     if (sw.start_stop) state_d = PAUSE;
            PAUSE:   if (sw.start_stop) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (sw.clear) state_d = IDLE;
    end

    // a tick coinciding with start_stop in RUN still counts before pausing
    always_comb begin
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        overflow_d = 1'b0;
        if (sw.clear) begin
            cnt_d   = '0;
            presc_d = '0;
        end else if (state_q == RUN && tick_q) begin
            if (presc_q == PRESC_MAX) begin
                presc_d    = '0;
                cnt_d      = bcd_inc(cnt_q);
                overflow_d = (cnt_q == WRAP_TIME);
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            cnt_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            running_q  <= (state_d == RUN);
            overflow_q <= overflow_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        hold_q, hold_d;
    logic [19:0] disp_q, disp_d;

    always_comb begin
        hold_d = hold_q;
        disp_d = disp_q;
        if (sw.clear) begin
            hold_d = 1'b0;
            disp_d = '0;
        end else if (state_q == RUN && sw.start_stop) begin
            hold_d = 1'b0;
        end else if (sw.lap) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else if (state_q == RUN) begin
                hold_d = 1'b1;
                disp_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_d;
            disp_q <= disp_d;
        end
    end

    assign sw.bcd_time = hold_q ? disp_q : cnt_q;
`else
    assign sw.bcd_time = cnt_q;
`endif

    assign sw.running  = running_q;
    assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core against a hundredths-count reference model
module tb_stopwatch_core;

    localparam int TICK_DIV = 10;

    logic clk50MHz = 1'b0;
    logic reset_n  = 1'b0;

    stopwatch_core_if sw();

    stopwatch_core #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(2)) dut (
        .clk50MHz (clk50MHz),
        .reset_n  (reset_n),
        .sw       (sw)
    );

    always #10 clk50MHz = ~clk50MHz;

    typedef struct {
        logic [19:0] bcd;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovf_seen = 0;

    // reference model: elapsed time as a plain hundredths count
    int   edge_n = 0;
    int   tick_at[$];
    int   m_mode;      // 0 idle, 1 run, 2 pause
    int   m_total;
    int   m_presc;
    bit   m_held;
    int   m_shown;
    bit   ck_cur = 1'b0;
    int   half_left = 2;
    bit   pl_pending = 1'b0;
    logic [19:0] pl_val;
    int   pl_total;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int t);
        int mn, sc, hn;
        mn = t / 6000;
        sc = (t / 100) % 60;
        hn = t % 100;
        return {4'(mn), 4'(sc / 10), 4'(sc % 10), 4'(hn / 10), 4'(hn % 10)};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk50MHz);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("bcd_time", sw.bcd_time, e.bcd);
                check("running", {19'd0, sw.running}, {19'd0, e.run});
                check("overflow", {19'd0, sw.overflow}, {19'd0, e.ovf});
                if (sw.overflow === 1'b1) ovf_seen++;
            end
        end
    end

    task automatic model_edge(input bit ss, input bit clr, input bit lp, input bit tk, output bit ovf);
        int old_total;
        ovf = 1'b0;
        old_total = m_total;
        if (clr) begin
            m_mode = 0; m_total = 0; m_presc = 0; m_held = 0; m_shown = 0;
        end else begin
            if (m_mode == 1 && tk) begin
                m_presc++;
                if (m_presc == TICK_DIV) begin
                    m_presc = 0;
                    m_total++;
                    if (m_total == 60000) begin
                        m_total = 0;
                        ovf = 1'b1;
                    end
                end
            end
            if (ss && m_mode == 1) m_held = 0;
            else if (lp) begin
                if (m_held) m_held = 0;
                else if (m_mode == 1) begin
                    m_held = 1;
                    m_shown = old_total;
                end
            end
            if (ss) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    task automatic drive(input bit ss, input bit clr, input bit lp, input bit ck, input bit rn);
        exp_t e;
        bit   tk;
        bit   ovf;
        int   e_idx;
        @(negedge clk50MHz);
        if (!rn) ck = 1'b0;
        sw.start_stop = ss;
        sw.clear      = clr;
        sw.clk1kHz    = ck;
        reset_n       = rn;
`ifdef STOPWATCH_LAP_HOLD_EN
        sw.lap        = lp;
`endif
        if (pl_pending) begin
            force dut.cnt_q = pl_val;
            m_total    = pl_total;
            pl_pending = 1'b0;
        end
        e_idx = edge_n + 1;
        ovf   = 1'b0;
        if (!rn) begin
            m_mode = 0; m_total = 0; m_presc = 0; m_held = 0; m_shown = 0;
            tick_at.delete();
        end else begin
            if (ck && !ck_cur) tick_at.push_back(e_idx + 3);
            tk = 1'b0;
            if (tick_at.size() > 0 && tick_at[0] == e_idx) begin
                tk = 1'b1;
                void'(tick_at.pop_front());
            end
            model_edge(ss, clr, lp, tk, ovf);
        end
        ck_cur = ck;
        e.bcd = m_held ? to_bcd(m_shown) : to_bcd(m_total);
        e.run = (m_mode == 1);
        e.ovf = ovf;
        exp_q.push_back(e);
        @(posedge clk50MHz);
        edge_n++;
    endtask

    function automatic bit next_ck();
        if (half_left == 0) begin
            half_left = $urandom_range(1, 4);
            return ~ck_cur;
        end
        half_left--;
        return ck_cur;
    endfunction

    // n rising edges of clk1kHz, then hold it low until the tick pipeline drains
    task automatic rises(input int n);
        int cnt;
        bit ck;
        cnt = 0;
        while (cnt < n) begin
            ck = next_ck();
            if (ck && !ck_cur) cnt++;
            drive(1'b0, 1'b0, 1'b0, ck, 1'b1);
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        half_left = 1;
    endtask

    // clear, start, then load the count register so the wrap region is reachable quickly
    task automatic preload(input logic [19:0] v, input int t);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        pl_val     = v;
        pl_total   = t;
        pl_pending = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 release dut.cnt_q;
    endtask

    task automatic sample(input string name, input logic [19:0] bcd, input bit run);
        #3;
        check({name, "_bcd"}, sw.bcd_time, bcd);
        check({name, "_run"}, {19'd0, sw.running}, {19'd0, run});
    endtask

    initial begin
        bit ss, clr, rn, ck;
        sw.clk1kHz = 1'b0; sw.start_stop = 1'b0; sw.clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
        sw.lap = 1'b0;
`endif
        m_mode = 0; m_total = 0; m_presc = 0; m_held = 0; m_shown = 0;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sample("reset", 20'h00000, 1'b0);
        check("reset_ovf", {19'd0, sw.overflow}, 20'd0);

        rises(40);
        sample("idle_ticks", 20'h00000, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises(250);
        sample("run250", 20'h00025, 1'b1);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises(74);
        sample("at007", 20'h00007, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises(30);
        sample("paused", 20'h00007, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises(5);
        sample("resume5", 20'h00007, 1'b1);
        rises(1);
        sample("resume6", 20'h00008, 1'b1);

        preload(20'h01234, 1234);
        rises(3);
        sample("pre1234", 20'h01234, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        sample("clr_ss", 20'h00000, 1'b0);
        rises(12);
        sample("clr_idle", 20'h00000, 1'b0);

        preload(20'h95995, 59995);
        ovf_seen = 0;
        rises(50);
        sample("wrap", 20'h00000, 1'b1);
        check("ovf_pulses", 20'(ovf_seen), 20'd1);

        for (int i = 0; i < 4000; i++) begin
            ss  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 399) == 0);
            rn  = ($urandom_range(0, 1499) != 0);
            ck  = next_ck();
            drive(ss, clr, 1'b0, ck, rn);
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef STOPWATCH_LAP_HOLD_EN
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises(1000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sample("lap_set", 20'h00100, 1'b1);
        rises(500);
        sample("lap_hold", 20'h00100, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sample("lap_rel", 20'h00150, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rises(20);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sample("lap_pause", 20'h00152, 1'b0);
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #5;
        check("drain", 20'(exp_q.size()), 20'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
